// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: widths, FSM states,
// WB mux select encodings and the long-unit result buffer entry.
package wb_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef enum logic {
      NORMAL = 1'b0,
      STARVE = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      SEL_PC4 = 2'd0,
      SEL_ALU = 2'd1,
      SEL_IMM = 2'd2,
      SEL_MEM = 2'd3
   } wb_sel_t;

   typedef struct packed {
      logic             live;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  dat;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-unit result buffer with per-entry kill by destination register.
// Ports: clk/rst, push/push_entry, pop, kill/kill_rd, head, full, empty,
// pending (one-hot OR of rd over live entries, bit 0 forced low).
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   input  logic             kill,
   input  logic [REG_W-1:0] kill_rd,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [31:0]      pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     cnt;

   assign head  = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i].live <= 1'b0;
         end
      end else begin
         // Kill first; a pop then retires the head slot, and a push
         // (never to the killed rd) lands in the tail slot.
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && mem[i].live && mem[i].rd == kill_rd) begin
               mem[i].live <= 1'b0;
            end
         end
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + PW'(1);
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].live) begin
            pending[mem[i].rd] = 1'b1;
         end
      end
      pending[0] = 1'b0;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter between pipeline WB and long-unit results.
// Ports: pipe_* (WB stage in, stall out), lu_* (valid/ready result in),
// rf_* (registered write port), pending_o (regs with buffered results).
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN         = wb_pkg::XLEN,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pipe_vld_i,
   input  logic             pipe_we_i,
   input  logic [REG_W-1:0] pipe_rd_i,
   input  logic [XLEN-1:0]  pipe_dat_i,
   output logic             pipe_stall_o,
   input  logic             lu_vld_i,
   output logic             lu_rdy_o,
   input  logic [REG_W-1:0] lu_rd_i,
   input  logic [XLEN-1:0]  lu_dat_i,
   output logic             rf_we_o,
   output logic [REG_W-1:0] rf_rd_o,
   output logic [XLEN-1:0]  rf_dat_o,
   output logic [31:0]      pending_o
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [SW-1:0]    cnt;
   logic [SW-1:0]    cnt_nxt;
   logic             pipe_wr;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic             wr_en;
   logic [REG_W-1:0] wr_rd;
   logic [XLEN-1:0]  wr_dat;
   wb_entry_t        head;
   wb_entry_t        push_entry;

   assign pipe_stall_o = (state == STARVE);
   assign pipe_wr = pipe_vld_i & pipe_we_i & (pipe_rd_i != '0)
                  & ~pipe_stall_o;
   assign lu_rdy_o = ~full;

   // Results to x0, or to the rd the pipeline writes this same cycle,
   // complete the handshake but are never buffered.
   assign push = lu_vld_i & lu_rdy_o & (lu_rd_i != '0)
               & ~(pipe_wr & (pipe_rd_i == lu_rd_i));
   assign push_entry = '{live: 1'b1, rd: lu_rd_i, dat: lu_dat_i};

   always_comb begin
      pop       = 1'b0;
      wr_en     = 1'b0;
      wr_rd     = pipe_rd_i;
      wr_dat    = pipe_dat_i;
      state_nxt = NORMAL;
      unique case (state)
         STARVE: begin
            pop    = ~empty;
            wr_en  = ~empty & head.live;
            wr_rd  = head.rd;
            wr_dat = head.dat;
         end
         default: begin
            if (pipe_wr) begin
               wr_en = 1'b1;
            end else if (~empty & head.live) begin
               pop    = 1'b1;
               wr_en  = 1'b1;
               wr_rd  = head.rd;
               wr_dat = head.dat;
            end
            // A killed head needs no write slot; retire it at once.
            if (~empty & ~head.live) begin
               pop = 1'b1;
            end
         end
      endcase
      cnt_nxt = (pop | empty) ? '0 : cnt + SW'(1);
      if (state == NORMAL && cnt_nxt == SW'(STARVE_LIMIT)) begin
         state_nxt = STARVE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= NORMAL;
         cnt      <= '0;
         rf_we_o  <= 1'b0;
         rf_rd_o  <= '0;
         rf_dat_o <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rf_we_o <= wr_en;
         if (wr_en) begin
            rf_rd_o  <= wr_rd;
            rf_dat_o <= wr_dat;
         end
      end
   end

   wb_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_entry(push_entry),
      .pop       (pop),
      .kill      (pipe_wr),
      .kill_rd   (pipe_rd_i),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .pending   (pending_o)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued
// when stimulus is driven and matched in order as rf_we_o pulses.
module tb_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        pipe_vld_i;
   logic        pipe_we_i;
   logic [4:0]  pipe_rd_i;
   logic [31:0] pipe_dat_i;
   logic        pipe_stall_o;
   logic        lu_vld_i;
   logic        lu_rdy_o;
   logic [4:0]  lu_rd_i;
   logic [31:0] lu_dat_i;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_dat_o;
   logic [31:0] pending_o;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] dat;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   wb_arbiter dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pipe_vld_i  (pipe_vld_i),
      .pipe_we_i   (pipe_we_i),
      .pipe_rd_i   (pipe_rd_i),
      .pipe_dat_i  (pipe_dat_i),
      .pipe_stall_o(pipe_stall_o),
      .lu_vld_i    (lu_vld_i),
      .lu_rdy_o    (lu_rdy_o),
      .lu_rd_i     (lu_rd_i),
      .lu_dat_i    (lu_dat_i),
      .rf_we_o     (rf_we_o),
      .rf_rd_o     (rf_rd_o),
      .rf_dat_o    (rf_dat_o),
      .pending_o   (pending_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic pv, input logic pw, input logic [4:0] prd,
                      input logic [31:0] pdat, input logic lv,
                      input logic [4:0] lrd, input logic [31:0] ldat);
      pipe_vld_i = pv;
      pipe_we_i  = pw;
      pipe_rd_i  = prd;
      pipe_dat_i = pdat;
      lu_vld_i   = lv;
      lu_rd_i    = lrd;
      lu_dat_i   = ldat;
   endtask

   task automatic expw(input logic [4:0] rd, input logic [31:0] dat);
      exp_t e;
      e.rd  = rd;
      e.dat = dat;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   // Every write the DUT makes must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (rst_i === 1'b0 && rf_we_o !== 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_write observed rd=%0d dat=%0h expected none",
                   rf_rd_o, rf_dat_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_rd", 64'(rf_rd_o), 64'(e.rd));
            chk("wr_dat", 64'(rf_dat_o), 64'(e.dat));
         end
      end
   end

   initial begin
      rst_i = 1'b1;
      drv(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      idle();
      @(negedge clk_i);
      chk("rst_we", 64'(rf_we_o), 64'(0));
      chk("rst_rdy", 64'(lu_rdy_o), 64'(1));
      chk("rst_pend", 64'(pending_o), 64'(0));
      chk("rst_stall", 64'(pipe_stall_o), 64'(0));
      chk("rst_rd", 64'(rf_rd_o), 64'(0));
      chk("rst_dat", 64'(rf_dat_o), 64'(0));
      step();
      step();

      // Idle drain
      step();
      drv(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD);
      expw(5'd5, 32'hDEAD);
      @(negedge clk_i);
      chk("drain_rdy", 64'(lu_rdy_o), 64'(1));
      step();
      idle();
      @(negedge clk_i);
      chk("drain_pend", 64'(pending_o), 64'h20);
      step();
      @(negedge clk_i);
      chk("drain_pend_clr", 64'(pending_o), 64'(0));
      step();
      @(negedge clk_i);
      chk("hold_we", 64'(rf_we_o), 64'(0));
      chk("hold_rd", 64'(rf_rd_o), 64'(5));
      chk("hold_dat", 64'(rf_dat_o), 64'hDEAD);

      // Pipeline priority and forced drain after starvation
      for (int i = 0; i < 7; i++) begin
         step();
         drv(1'b1, 1'b1, 5'd3, 32'h10 + i, (i == 0), 5'd7, 32'h77);
         if (i == 5) expw(5'd7, 32'h77);
         else        expw(5'd3, 32'h10 + i);
         @(negedge clk_i);
         chk("prio_stall", 64'(pipe_stall_o), 64'(i == 5));
         if (i == 3) chk("prio_pend", 64'(pending_o), 64'h80);
         if (i == 6) chk("prio_pend_clr", 64'(pending_o), 64'(0));
      end

      // Full buffer back-pressure
      for (int i = 0; i < 9; i++) begin
         step();
         drv((i < 7), 1'b1, 5'd3, 32'h20 + i, (i <= 6),
             (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10,
             (i == 0) ? 32'h88 : (i == 1) ? 32'h99 : 32'hA0);
         if (i <= 4 || i == 6) expw(5'd3, 32'h20 + i);
         else if (i == 5)      expw(5'd8, 32'h88);
         else if (i == 7)      expw(5'd9, 32'h99);
         else                  expw(5'd10, 32'hA0);
         @(negedge clk_i);
         chk("full_rdy", 64'(lu_rdy_o), 64'(i <= 1 || i == 6 || i == 8));
         chk("full_stall", 64'(pipe_stall_o), 64'(i == 5));
         if (i == 2) chk("full_pend", 64'(pending_o), 64'h300);
      end

      // Write-after-write kill
      step();
      drv(1'b1, 1'b1, 5'd3, 32'h31, 1'b1, 5'd4, 32'hAA);
      expw(5'd3, 32'h31);
      step();
      drv(1'b1, 1'b1, 5'd4, 32'hBB, 1'b0, 5'd0, 32'h0);
      expw(5'd4, 32'hBB);
      @(negedge clk_i);
      chk("waw_pend", 64'(pending_o), 64'h10);
      step();
      idle();
      @(negedge clk_i);
      chk("waw_pend_clr", 64'(pending_o), 64'(0));
      step();
      @(negedge clk_i);
      chk("waw_rdy", 64'(lu_rdy_o), 64'(1));
      chk("waw_stall", 64'(pipe_stall_o), 64'(0));

      // Same-cycle kill, x0 targets, and a non-writing instruction
      step();
      drv(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67);
      expw(5'd6, 32'h66);
      @(negedge clk_i);
      chk("kill_rdy", 64'(lu_rdy_o), 64'(1));
      step();
      drv(1'b1, 1'b1, 5'd0, 32'h70, 1'b1, 5'd0, 32'h05);
      @(negedge clk_i);
      chk("kill_pend", 64'(pending_o), 64'(0));
      chk("x0_rdy", 64'(lu_rdy_o), 64'(1));
      step();
      drv(1'b1, 1'b0, 5'd12, 32'h71, 1'b0, 5'd0, 32'h0);
      @(negedge clk_i);
      chk("x0_pend", 64'(pending_o), 64'(0));
      step();
      idle();
      step();
      step();
      @(negedge clk_i);
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
